// File: rtl/pkt_bridge_fifo.sv
// Packet-aware FIFO: words are written into a pending region and become visible to the
// reader only on commit; abort (or a commit of a packet that overflowed) discards them.
module pkt_bridge_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned AFULL_LEVEL = 56
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  w_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  commit,
  input  logic                  abort,
  input  logic                  r_enable,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_BITS:0]    count,
  output logic [ADDR_BITS:0]    pending,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StPkt, StPoison} state_e;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_BITS:0]    r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  state_e                r_state;
  logic                  r_overflow, r_underflow, r_drop;
  logic [DATA_WIDTH-1:0] r_data_q;

  logic [ADDR_BITS:0]    w_total, w_wr_ptr_inc, w_wr_ptr_d, w_cmt_ptr_d;
  state_e                w_state_d;
  logic                  w_wr_ok, w_wr_drop, w_rd_ok, w_rd_unf;
  logic                  w_poisoned, w_discard, w_drop_d;

  assign w_total     = r_wr_ptr - r_rd_ptr;
  assign count       = r_cmt_ptr - r_rd_ptr;
  assign pending     = r_wr_ptr - r_cmt_ptr;
  assign empty       = (count == '0);
  assign full        = (w_total == (ADDR_BITS + 1)'(DEPTH));
  assign almost_full = (32'(w_total) >= AFULL_LEVEL);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign drop        = r_drop;
  assign r_data      = r_data_q;

  assign w_wr_ok      = w_enable & ~full;
  assign w_wr_drop    = w_enable & full;
  assign w_rd_ok      = r_enable & ~empty;
  assign w_rd_unf     = r_enable & empty;
  assign w_wr_ptr_inc = r_wr_ptr + {{ADDR_BITS{1'b0}}, w_wr_ok};

  // A write dropped this cycle poisons the packet before commit is evaluated.
  assign w_poisoned = (r_state == StPoison) | w_wr_drop;
  assign w_discard  = (abort & ((r_state != StIdle) | w_enable)) | (commit & w_poisoned);

  always_comb begin
    w_state_d   = r_state;
    w_wr_ptr_d  = w_wr_ptr_inc;
    w_cmt_ptr_d = r_cmt_ptr;
    w_drop_d    = 1'b0;
    if (w_discard) begin
      w_wr_ptr_d = r_cmt_ptr;
      w_state_d  = StIdle;
      w_drop_d   = 1'b1;
    end else if (commit) begin
      w_cmt_ptr_d = w_wr_ptr_inc;
      w_state_d   = StIdle;
    end else if (w_wr_drop) begin
      w_state_d = StPoison;
    end else if (w_wr_ok && r_state == StIdle) begin
      w_state_d = StPkt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr    <= '0;
      r_cmt_ptr   <= '0;
      r_rd_ptr    <= '0;
      r_state     <= StIdle;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_drop      <= 1'b0;
      r_data_q    <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_d;
      r_cmt_ptr   <= w_cmt_ptr_d;
      r_state     <= w_state_d;
      r_drop      <= w_drop_d;
      r_overflow  <= w_wr_drop | (r_overflow & ~clear_err);
      r_underflow <= w_rd_unf | (r_underflow & ~clear_err);
      if (w_rd_ok) begin
        r_data_q <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= w_data;
  end

endmodule

// File: tb/tb_pkt_bridge_fifo.sv
// Bench for pkt_bridge_fifo: directed scenarios plus randomized traffic checked against a
// queue-based packet model (committed queue, pending queue, poison flag).
module tb_pkt_bridge_fifo;
  localparam int DEPTH = 64;
  localparam int AFL   = 56;
  localparam logic [27:0] RstVec = 28'h800_0000;

  logic       clk = 1'b0;
  logic       n_rst, w_enable, commit, abort, r_enable, clear_err;
  logic [7:0] w_data, r_data;
  logic       empty, full, almost_full, overflow, underflow, drop;
  logic [6:0] count, pending;

  pkt_bridge_fifo #(.DATA_WIDTH(8), .ADDR_BITS(6), .AFULL_LEVEL(56)) dut (
    .clk(clk), .n_rst(n_rst), .w_enable(w_enable), .w_data(w_data), .commit(commit),
    .abort(abort), .r_enable(r_enable), .clear_err(clear_err), .r_data(r_data),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .pending(pending), .overflow(overflow), .underflow(underflow), .drop(drop)
  );

  always #5 clk = ~clk;

  wire [27:0] obs = {empty, full, almost_full, count, pending, overflow, underflow, drop, r_data};

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cq[$];
  logic [7:0] pq[$];
  bit         m_poison, m_ovf, m_unf, m_drop;
  logic [7:0] m_rdata;

  function automatic logic [27:0] m_vec();
    int tot = cq.size() + pq.size();
    return {cq.size() == 0, tot == DEPTH, tot >= AFL, 7'(cq.size()), 7'(pq.size()),
            m_ovf, m_unf, m_drop, m_rdata};
  endfunction

  task automatic model_reset();
    cq.delete(); pq.delete();
    m_poison = 0; m_ovf = 0; m_unf = 0; m_drop = 0; m_rdata = 8'h00;
  endtask

  task automatic idle_in();
    w_enable = 0; w_data = 8'h00; commit = 0; abort = 0; r_enable = 0; clear_err = 0;
  endtask

  // One clock edge: advance the packet model with the inputs currently applied, then settle.
  task automatic cyc();
    int tot;
    bit fullm, emptym, had_pkt, disc, new_ovf, new_unf;
    @(posedge clk);
    tot     = cq.size() + pq.size();
    fullm   = (tot == DEPTH);
    emptym  = (cq.size() == 0);
    had_pkt = (pq.size() != 0) || m_poison;
    new_ovf = 0; new_unf = 0; m_drop = 0;
    if (r_enable) begin
      if (!emptym) m_rdata = cq.pop_front();
      else new_unf = 1;
    end
    if (w_enable) begin
      if (!fullm) pq.push_back(w_data);
      else begin new_ovf = 1; m_poison = 1; end
    end
    disc = (abort && (had_pkt || w_enable)) || (commit && m_poison);
    if (disc) begin
      pq.delete(); m_poison = 0; m_drop = 1;
    end else if (commit) begin
      while (pq.size() != 0) cq.push_back(pq.pop_front());
      m_poison = 0;
    end
    m_ovf = new_ovf | (m_ovf & !clear_err);
    m_unf = new_unf | (m_unf & !clear_err);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    n_rst = 0;
    model_reset();
    @(negedge clk);
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_in();
    n_rst = 0;
    model_reset();
    #1;
    n_cmp++;
    if (obs !== RstVec) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs, RstVec);
    end
    @(negedge clk);
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w_enable = 1; w_data = exp[i]; cyc();
    end
    w_enable = 0;
    n_cmp++;
    if ({empty, count, pending} !== {1'b1, 7'd0, 7'd3}) begin
      n_err++; $display("FAIL basic_pending: got %b/%0d/%0d want 1/0/3", empty, count, pending);
    end
    commit = 1; cyc(); commit = 0;
    n_cmp++;
    if ({empty, count, pending} !== {1'b0, 7'd3, 7'd0}) begin
      n_err++; $display("FAIL basic_commit: got %b/%0d/%0d want 0/3/0", empty, count, pending);
    end
    r_enable = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (r_data !== exp[i]) begin
        n_err++; $display("FAIL basic_read%0d: got %h want %h", i, r_data, exp[i]);
      end
    end
    r_enable = 0;
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++; $display("FAIL basic_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w_enable = 1; w_data = 8'(8'hC0 + i); cyc();
    end
    w_enable = 0; abort = 1; cyc(); abort = 0;
    n_cmp++;
    if ({drop, count, pending} !== {1'b1, 7'd0, 7'd0}) begin
      n_err++; $display("FAIL abort_drop: got %b/%0d/%0d want 1/0/0", drop, count, pending);
    end
    w_enable = 1; w_data = 8'hA5; cyc();
    n_cmp++;
    if (drop !== 1'b0) begin
      n_err++; $display("FAIL abort_single_pulse: got %b want 0", drop);
    end
    w_data = 8'h5A; cyc();
    w_enable = 0; commit = 1; cyc(); commit = 0;
    n_cmp++;
    if (count !== 7'd2) begin
      n_err++; $display("FAIL abort_recommit_count: got %0d want 2", count);
    end
    r_enable = 1; cyc();
    n_cmp++;
    if (r_data !== 8'hA5) begin
      n_err++; $display("FAIL abort_read0: got %h want a5", r_data);
    end
    cyc(); r_enable = 0;
    n_cmp++;
    if ({r_data, empty} !== {8'h5A, 1'b1}) begin
      n_err++; $display("FAIL abort_read1: got %h/%b want 5a/1", r_data, empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    w_enable = 1;
    for (int i = 0; i < DEPTH; i++) begin
      w_data = 8'(i); cyc();
    end
    n_cmp++;
    if ({full, almost_full, pending, overflow} !== {1'b1, 1'b1, 7'd64, 1'b0}) begin
      n_err++; $display("FAIL ovf_fill: got %b%b/%0d/%b want 11/64/0",
                        full, almost_full, pending, overflow);
    end
    w_data = 8'hEE; cyc(); w_enable = 0;
    n_cmp++;
    if ({full, overflow, pending} !== {1'b1, 1'b1, 7'd64}) begin
      n_err++; $display("FAIL ovf_drop_write: got %b%b/%0d want 11/64", full, overflow, pending);
    end
    commit = 1; cyc(); commit = 0;
    n_cmp++;
    if ({drop, full, count, pending} !== {1'b1, 1'b0, 7'd0, 7'd0}) begin
      n_err++; $display("FAIL ovf_poison_commit: got %b%b/%0d/%0d want 10/0/0",
                        drop, full, count, pending);
    end
    clear_err = 1; cyc(); clear_err = 0;
    n_cmp++;
    if ({overflow, drop} !== 2'b00) begin
      n_err++; $display("FAIL ovf_clear: got %b%b want 00", overflow, drop);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    w_enable = 1;
    for (int i = 0; i < 60; i++) begin
      w_data = 8'(i * 3); cyc();
    end
    w_enable = 0; commit = 1; cyc(); commit = 0;
    n_cmp++;
    if ({count, almost_full} !== {7'd60, 1'b1}) begin
      n_err++; $display("FAIL wrap_commit60: got %0d/%b want 60/1", count, almost_full);
    end
    r_enable = 1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      n_cmp++;
      if (r_data !== 8'(i * 3)) begin
        n_err++; $display("FAIL wrap_read_a%0d: got %h want %h", i, r_data, 8'(i * 3));
      end
    end
    r_enable = 0; w_enable = 1;
    for (int i = 0; i < 10; i++) begin
      w_data = 8'(100 + i); cyc();
    end
    w_enable = 0; commit = 1; cyc(); commit = 0;
    n_cmp++;
    if ({count, almost_full, full} !== {7'd10, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL wrap_commit10: got %0d/%b%b want 10/00", count, almost_full, full);
    end
    r_enable = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (r_data !== 8'(100 + i)) begin
        n_err++; $display("FAIL wrap_read_b%0d: got %h want %h", i, r_data, 8'(100 + i));
      end
    end
    r_enable = 0;
  endtask

  task automatic test_misc();
    do_reset();
    w_enable = 1; w_data = 8'h77; commit = 1; cyc(); w_enable = 0; commit = 0;
    n_cmp++;
    if ({count, pending, drop} !== {7'd1, 7'd0, 1'b0}) begin
      n_err++; $display("FAIL misc_wr_commit: got %0d/%0d/%b want 1/0/0", count, pending, drop);
    end
    r_enable = 1; cyc(); cyc(); r_enable = 0;
    n_cmp++;
    if ({underflow, r_data, empty} !== {1'b1, 8'h77, 1'b1}) begin
      n_err++; $display("FAIL misc_underflow: got %b/%h/%b want 1/77/1", underflow, r_data, empty);
    end
    r_enable = 1; clear_err = 1; cyc(); r_enable = 0;
    n_cmp++;
    if (underflow !== 1'b1) begin
      n_err++; $display("FAIL misc_err_priority: got %b want 1", underflow);
    end
    cyc(); clear_err = 0;
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_err++; $display("FAIL misc_clear: got %b want 0", underflow);
    end
    w_enable = 1; w_data = 8'h01; cyc(); w_data = 8'h02; cyc(); w_enable = 0;
    commit = 1; abort = 1; cyc(); commit = 0; abort = 0;
    n_cmp++;
    if ({drop, count, pending} !== {1'b1, 7'd0, 7'd0}) begin
      n_err++; $display("FAIL misc_commit_abort: got %b/%0d/%0d want 1/0/0", drop, count, pending);
    end
    abort = 1; cyc(); abort = 0;
    n_cmp++;
    if (drop !== 1'b0) begin
      n_err++; $display("FAIL misc_idle_abort: got %b want 0", drop);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    w_enable = 1;
    for (int i = 0; i < 5; i++) begin
      w_data = 8'(i + 1); cyc();
    end
    w_enable = 0; commit = 1; cyc(); commit = 0; w_enable = 1;
    for (int i = 0; i < 3; i++) begin
      w_data = 8'(i + 9); cyc();
    end
    w_enable = 0; r_enable = 1; cyc(); r_enable = 0;
    n_cmp++;
    if ({count, pending} !== {7'd4, 7'd3}) begin
      n_err++; $display("FAIL areset_setup: got %0d/%0d want 4/3", count, pending);
    end
    #2;
    n_rst = 0;
    #1;
    n_cmp++;
    if (obs !== RstVec) begin
      n_err++; $display("FAIL areset_immediate: got %h want %h", obs, RstVec);
    end
    model_reset();
    @(negedge clk);
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int rdp [4] = '{20, 50, 85, 35};
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        w_enable  = ($urandom_range(99) < 75);
        w_data    = 8'($urandom);
        r_enable  = ($urandom_range(99) < rdp[ph]);
        commit    = ($urandom_range(99) < 8);
        abort     = ($urandom_range(99) < 3);
        clear_err = ($urandom_range(99) < 4);
        cyc();
        n_cmp++;
        if (obs !== m_vec()) begin
          n_err++; $display("FAIL random_ph%0d_cyc%0d: got %h want %h", ph, i, obs, m_vec());
        end
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    n_rst = 1;
    test_reset();
    test_basic();
    test_abort();
    test_overflow();
    test_wrap();
    test_misc();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
